systolic_bus_master: RTL and testbench

SYSTOLIC_BUS_MASTER -- requirements
Module: systolic_bus_master

---
 rtl/systolic_bus_master.sv | 159 +++++++++++++++
 tb/tb_systolic_bus_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_bus_master.sv
// Host-to-peripheral sequencer: streams 48 operand bytes into the array, kicks it,
// waits for a done edge (or gives up), then streams the result bytes back to the host.
module systolic_bus_master #(
    parameter int TIMEOUT  = 1023,
    parameter int RD_BASE  = 48,
    parameter int RD_COUNT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       error,
    output logic       xfer_done,
    output logic [5:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_write_en,
    output logic       bus_read_en,
    output logic       bus_start,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ready,
    input  logic       bus_done
);
    localparam int              TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [5:0]      LAST_WR = 6'd47;
    localparam logic [4:0]      LAST_RD = 5'(RD_COUNT - 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]      RD_ADDR = 6'(RD_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_FIN
    } state_t;

    state_t        state;
    logic [5:0]    wr_idx;
    logic [4:0]    rd_idx;
    logic [TW-1:0] tmo_cnt;
    logic          done_q;

    // The peripheral handshake carries no backpressure this block needs to honour.
    logic unused_bus_ready;
    assign unused_bus_ready = bus_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_idx       <= '0;
            rd_idx       <= '0;
            tmo_cnt      <= '0;
            done_q       <= 1'b0;
            in_ready     <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            xfer_done    <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_write_en <= 1'b0;
            bus_read_en  <= 1'b0;
            bus_start    <= 1'b0;
        end else begin
            done_q       <= bus_done;
            // Strobes and bus fields are single-cycle; idle bus reads as all zero.
            bus_write_en <= 1'b0;
            bus_read_en  <= 1'b0;
            bus_start    <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            xfer_done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        wr_idx   <= '0;
                        rd_idx   <= '0;
                        in_ready <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        bus_write_en <= 1'b1;
                        bus_addr     <= wr_idx;
                        bus_wdata    <= in_data;
                        wr_idx       <= wr_idx + 6'd1;
                        if (wr_idx == LAST_WR) begin
                            in_ready <= 1'b0;
                            state    <= S_START;
                        end
                    end
                end

                // Entered while the final write strobe is on the bus, so the kick
                // lands one cycle later and never overlaps it.
                S_START: begin
                    bus_start <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (bus_done && !done_q) begin
                        rd_idx <= '0;
                        state  <= S_READ;
                    end else if (tmo_cnt == TO_LAST) begin
                        error     <= 1'b1;
                        xfer_done <= 1'b1;
                        state     <= S_FIN;
                    end
                end

                S_READ: begin
                    if (bus_read_en) begin
                        out_data  <= bus_rdata;
                        out_valid <= 1'b1;
                    end else if (out_valid) begin
                        // Issue the next fetch on the accept edge: one byte per two cycles.
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (rd_idx == LAST_RD) begin
                                xfer_done <= 1'b1;
                                state     <= S_FIN;
                            end else begin
                                rd_idx      <= rd_idx + 5'd1;
                                bus_read_en <= 1'b1;
                                bus_addr    <= RD_ADDR + {1'b0, rd_idx + 5'd1};
                            end
                        end
                    end else begin
                        bus_read_en <= 1'b1;
                        bus_addr    <= RD_ADDR + {1'b0, rd_idx};
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_bus_master.sv
// Scenario table plus hand sequences for systolic_bus_master, with a transaction-level
// expectation (48 ordered writes, one kick, ordered result reads) and bus protocol watch.
module tb_systolic_bus_master;
    localparam int TO = 60;
    localparam int RB = 48;
    localparam int RC = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy, error, xfer_done;
    logic [5:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_write_en, bus_read_en, bus_start;
    logic [7:0] bus_rdata;
    logic       bus_ready = 1'b1;
    logic       bus_done = 1'b0;

    systolic_bus_master #(.TIMEOUT(TO), .RD_BASE(RB), .RD_COUNT(RC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .error(error), .xfer_done(xfer_done),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write_en(bus_write_en), .bus_read_en(bus_read_en), .bus_start(bus_start),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_done(bus_done)
    );

    always #5 clk = ~clk;

    // Peripheral result memory, read combinationally.
    logic [7:0] res_mem [64];
    assign bus_rdata = bus_read_en ? res_mem[bus_addr] : 8'h00;

    int total = 0;
    int bad = 0;
    int stall_cfg = 0;
    logic [7:0] tx_bytes [48];

    // Monitor state: only the monitor writes these.
    int cyc = 0, viol = 0, n_start = 0, n_done = 0, start_cyc = 0, done_cyc = 0, raise_cyc = 0;
    logic [5:0] wa_q [$];
    logic [7:0] wd_q [$];
    logic [5:0] ra_q [$];
    int         lat_q [$];
    logic [7:0] out_q [$];
    logic       prev_done = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus_write_en) begin
            wa_q.push_back(bus_addr);
            wd_q.push_back(bus_wdata);
        end
        if (bus_read_en) begin
            ra_q.push_back(bus_addr);
            lat_q.push_back(cyc - raise_cyc);
        end
        if (bus_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (xfer_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (bus_done && !prev_done) raise_cyc <= cyc;
        prev_done <= bus_done;
        if ((int'(bus_write_en) + int'(bus_read_en) + int'(bus_start) > 1) ||
            (!bus_write_en && bus_wdata != 8'h00) ||
            (!bus_write_en && !bus_read_en && bus_addr != 6'd0) ||
            (bus_read_en && out_valid) ||
            ((!busy || xfer_done) && (bus_write_en || bus_read_en || bus_start)) ||
            (prev_stall && out_data != prev_data))
            viol <= viol + 1;
        prev_stall <= out_valid && !out_ready;
        prev_data  <= out_data;
    end

    // Host receiver: holds out_ready low for a configurable number of valid cycles per byte.
    initial begin
        int waitc = 0;
        int tgt = 0;
        forever begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (waitc == 0) tgt = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
                if (waitc >= tgt) out_ready = 1'b1;
                else begin
                    out_ready = 1'b0;
                    waitc++;
                end
            end else begin
                out_ready = 1'b0;
                waitc = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (limit 90000 cycles)");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; cmd_start = 1'b1;
        @(posedge clk); #1; cmd_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int bud = 0;
            int g;
            in_data = tx_bytes[i];
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && bud < 100) begin
                @(negedge clk);
                bud++;
            end
            if (!in_ready) begin
                chk("in_ready_wait", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data = 8'h00;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    typedef struct {
        int gap;        // idle cycles between input bytes (-1 random)
        int stall;      // out_ready hold-off per result byte (-1 random)
        int mode;       // 0 done edge after lat, 1 never done, 2 stale done level
        int lat;
        int poke;       // pulse cmd_start while waiting
        int exp_err;
        int exp_reads;
    } vec_t;

    task automatic run_tx(input vec_t v);
        int wb, rb, ob, sb, db, vb, lb, bud, mism;
        for (int i = 0; i < 48; i++) tx_bytes[i] = 8'($urandom);
        for (int a = 0; a < 64; a++) res_mem[a] = 8'($urandom);
        stall_cfg = v.stall;
        @(negedge clk);
        wb = wa_q.size(); rb = ra_q.size(); ob = out_q.size();
        sb = n_start; db = n_done; vb = viol; lb = lat_q.size();
        if (v.mode == 2) begin
            @(posedge clk); #1; bus_done = 1'b1;
        end
        pulse_start();
        send_bytes(48, v.gap);
        bud = 0;
        while (n_start == sb && bud < 200) begin
            @(negedge clk);
            bud++;
        end
        if (n_start == sb) chk("start_wait", 0, 1);
        if (v.poke != 0) pulse_start();
        if (v.mode == 0) begin
            for (int k = 0; k < v.lat; k++) @(posedge clk);
            #1; bus_done = 1'b1;
        end else if (v.mode == 2) begin
            repeat (3) @(posedge clk);
            #1; bus_done = 1'b0;
            repeat (3) @(posedge clk);
            #1; bus_done = 1'b1;
        end
        bud = 0;
        while (n_done == db && bud < 3000) begin
            @(negedge clk);
            bud++;
        end
        if (n_done == db) chk("done_wait", 0, 1);
        repeat (3) @(posedge clk);
        #1; bus_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("wr_count", wa_q.size() - wb, 48);
        mism = 0;
        for (int i = 0; i < 48; i++)
            if (wb + i >= wa_q.size() || wa_q[wb + i] != 6'(i) || wd_q[wb + i] != tx_bytes[i]) mism++;
        chk("wr_addr_data", mism, 0);
        chk("start_count", n_start - sb, 1);
        chk("done_count", n_done - db, 1);
        chk("error_flag", int'(error), v.exp_err);
        chk("busy_after", int'(busy), 0);
        chk("rd_count", ra_q.size() - rb, v.exp_reads);
        chk("out_count", out_q.size() - ob, v.exp_reads);
        mism = 0;
        for (int i = 0; i < v.exp_reads; i++) begin
            if (rb + i >= ra_q.size() || ra_q[rb + i] != 6'(RB + i)) mism++;
            if (ob + i >= out_q.size() || out_q[ob + i] != res_mem[RB + i]) mism++;
        end
        chk("rd_addr_data", mism, 0);
        if (v.exp_err != 0) chk("timeout_len", done_cyc - start_cyc, TO);
        else chk("done_to_read", (lat_q.size() > lb) ? lat_q[lb] : -1, 2);
        chk("protocol", viol - vb, 0);
    endtask

    vec_t tbl [7];

    initial begin
        int wb, vb;
        tbl[0] = '{0,  0,  0, 3,  0, 0, RC};   // full run, in_valid held high
        tbl[1] = '{1,  5,  0, 7,  0, 0, RC};   // host stall both directions
        tbl[2] = '{-1, -1, 0, 20, 0, 0, RC};   // random pacing
        tbl[3] = '{0,  0,  1, 0,  0, 1, 0};    // done never arrives
        tbl[4] = '{0,  2,  2, 0,  0, 0, RC};   // stale done level before kick
        tbl[5] = '{0,  0,  0, 12, 1, 0, RC};   // cmd_start while busy
        tbl[6] = '{-1, -1, 0, 1,  0, 0, RC};   // random pacing, immediate done

        #2;
        chk("reset_outputs", int'({busy, error, xfer_done, in_ready, out_valid, out_data, bus_addr,
                                   bus_wdata, bus_write_en, bus_read_en, bus_start}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", int'({busy, in_ready}), 0);

        for (int t = 0; t < 7; t++) begin
            run_tx(tbl[t]);
            if (t == 3) begin
                repeat (4) @(posedge clk);
                #1;
                chk("error_sticky", int'(error), 1);
            end
        end

        // Reset in the middle of loading.
        for (int i = 0; i < 48; i++) tx_bytes[i] = 8'($urandom);
        stall_cfg = 0;
        @(negedge clk);
        wb = wa_q.size();
        vb = viol;
        pulse_start();
        send_bytes(20, 0);
        in_data = tx_bytes[20];
        in_valid = 1'b1;
        @(negedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({busy, error, xfer_done, in_ready, out_valid, out_data, bus_addr,
                                         bus_wdata, bus_write_en, bus_read_en, bus_start}), 0);
        in_valid = 1'b0;
        chk("partial_writes", wa_q.size() - wb, 20);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wb = wa_q.size();
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("no_start_after_reset", int'({busy, in_ready}), 0);
        chk("no_writes_after_reset", wa_q.size() - wb, 0);
        chk("protocol_reset", viol - vb, 0);
        run_tx(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
